// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage: PC, ROM address, IF/ID register, fault halt
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_if,
  input  logic                   stall_id,
  input  logic                   flush_id,
  input  logic                   redirect_en,
  input  logic [31:0]            redirect_pc,
  output logic [31:0]            rom_addr,
  input  logic [31:0]            rom_data,
  output logic [31:0]            id_inst,
  output logic [31:0]            id_pc,
  output logic [31:0]            id_pc_plus4,
  output logic                   id_valid,
  output logic                   fault,
  output logic [31:0]            fault_pc,
  output logic [COUNT_WIDTH-1:0] fetch_count
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [31:0]            pc_q, pc_d;
  logic [31:0]            id_inst_q, id_inst_d;
  logic [31:0]            id_pc_q, id_pc_d;
  logic [31:0]            id_pc_plus4_q, id_pc_plus4_d;
  logic                   id_valid_q, id_valid_d;
  logic                   fault_q, fault_d;
  logic [31:0]            fault_pc_q, fault_pc_d;
  logic [COUNT_WIDTH-1:0] fetch_count_q, fetch_count_d;
  logic [31:0]            pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    id_inst_d     = id_inst_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;
    id_valid_d    = id_valid_q;
    fault_d       = fault_q;
    fault_pc_d    = fault_pc_q;
    fetch_count_d = fetch_count_q;

    // A misaligned redirect parks the fetch unit until reset; the PC is left untouched.
    if (state_q == ST_RUN) begin
      if (redirect_en) begin
        if (redirect_pc[1:0] == 2'b00) begin
          pc_d = redirect_pc;
        end else begin
          fault_d    = 1'b1;
          fault_pc_d = redirect_pc;
          state_d    = ST_HALT;
        end
      end else if (!stall_if) begin
        pc_d = pc_plus4;
      end
    end

    // Bubbles clear inst/valid only; id_pc and id_pc_plus4 keep their last values.
    if (flush_id || redirect_en) begin
      id_inst_d  = 32'd0;
      id_valid_d = 1'b0;
    end else if (!stall_id) begin
      if ((state_q == ST_HALT) || stall_if) begin
        id_inst_d  = 32'd0;
        id_valid_d = 1'b0;
      end else begin
        id_inst_d     = rom_data;
        id_pc_d       = pc_q;
        id_pc_plus4_d = pc_plus4;
        id_valid_d    = 1'b1;
        fetch_count_d = fetch_count_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      id_inst_q     <= 32'd0;
      id_pc_q       <= 32'd0;
      id_pc_plus4_q <= 32'd0;
      id_valid_q    <= 1'b0;
      fault_q       <= 1'b0;
      fault_pc_q    <= 32'd0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      id_inst_q     <= id_inst_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
      id_valid_q    <= id_valid_d;
      fault_q       <= fault_d;
      fault_pc_q    <= fault_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign rom_addr    = {2'b00, pc_q[31:2]};
  assign id_inst     = id_inst_q;
  assign id_pc       = id_pc_q;
  assign id_pc_plus4 = id_pc_plus4_q;
  assign id_valid    = id_valid_q;
  assign fault       = fault_q;
  assign fault_pc    = fault_pc_q;
  assign fetch_count = fetch_count_q;

endmodule
